regfile_dump_reader: RTL

- Read-side initiator for the register file's debug probe port (`prodeInd` / `prode`).
- On a start pulse it sweeps a range of register indices and snapshots each register through the probe port.
- It serialises each register as a 5-byte record (index byte, then data MSB first) onto a valid/ready byte stream that feeds the board UART / debug link.
- It sits beside the datapath and never touches the `WE3` write path.

---
 rtl/regfile_dump_reader_if.sv | 19 +
 rtl/regfile_dump_reader.sv | 115 +++++++++++
 2 files changed

// File: rtl/regfile_dump_reader_if.sv
// Byte stream from the register dump reader to the UART / debug link.
// Plain valid/ready handshake: the byte moves when both are high at posedge.
interface regfile_dump_reader_if;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Sweeps register file probe indices and streams each register
// as a 5-byte record: index byte, then data MSB first.
module regfile_dump_reader #(
  parameter int FIRST_REG = 0,
  parameter int LAST_REG  = 31
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic [4:0]                    prode_idx,
  input  logic [31:0]                   prode_data,
  regfile_dump_reader_if.master         strm,
  output logic                          busy,
  output logic                          done
);

  generate
    if (FIRST_REG < 0 || LAST_REG > 31 || FIRST_REG > LAST_REG) begin : g_bad
      $error("regfile_dump_reader: illegal FIRST_REG/LAST_REG");
    end
  endgenerate

  localparam logic [4:0] FIRST = 5'(FIRST_REG);
  localparam logic [4:0] LAST  = 5'(LAST_REG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CAPTURE,
    S_SEND,
    S_DONE
  } state_t;

  state_t      r_state;
  logic [4:0]  r_idx;
  logic [39:0] r_shift;
  logic [2:0]  r_cnt;
  logic        r_valid;
  logic        r_busy;
  logic        r_done;
  logic        w_hs;

  assign w_hs          = r_valid && strm.out_ready;
  assign prode_idx     = r_idx;
  assign strm.out_data = r_shift[39:32];
  assign strm.out_valid = r_valid;
  assign busy          = r_busy;
  assign done          = r_done;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_idx   <= FIRST;
      r_shift <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_idx   <= FIRST;
            r_busy  <= 1'b1;
            r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          if (abort) begin
            r_idx   <= FIRST;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_shift <= {3'b000, r_idx, prode_data};
            r_cnt   <= '0;
            r_valid <= 1'b1;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          // a byte accepted alongside abort is delivered; nothing follows it
          if (abort) begin
            r_valid <= 1'b0;
            r_idx   <= FIRST;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_hs) begin
            r_shift <= {r_shift[31:0], 8'h00};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'd4) begin
              r_valid <= 1'b0;
              if (r_idx == LAST) begin
                r_done  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_idx   <= r_idx + 5'd1;
                r_state <= S_CAPTURE;
              end
            end
          end
        end
        S_DONE: begin
          r_idx   <= FIRST;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
